link_pair_router: RTL and testbench



---
 rtl/link_pair_pkg.sv | 26 ++
 rtl/link_pair_matcher.sv | 51 +++++
 rtl/link_pair_router.sv | 168 ++++++++++++++++
 tb/tb_link_pair_router.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/link_pair_pkg.sv
// link_pair_pkg
// Shared definitions for the pair-lane router:
//   - state_t    : router state (IDLE, SEEK, LINK)
//   - map_pair   : logical pair index -> physical pair index for a mapping
//   - cnt_width  : bits needed to hold a counter value 0..limit
package link_pair_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    LINK = 2'd2
  } state_t;

  // Crossed cabling swaps pairs in adjacent couples (0<->1, 2<->3, ...).
  function automatic int map_pair(input int k, input logic crossed);
    return crossed ? (k ^ 1) : k;
  endfunction

  // Width of a counter that must represent 0..limit without wrapping.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/link_pair_matcher.sv
// link_pair_matcher
// Combinational remap of physical pair symbols into logical order and
// comparison of each logical pair against its training symbol.
// Ports:
//   rx_symbol     in  PAIRS*WIDTH  physical pair p at [p*WIDTH +: WIDTH]
//   rx_valid      in  PAIRS        per-physical-pair valid
//   crossed       in  1            mapping under test / in use
//   mapped_symbol out PAIRS*WIDTH  symbols in logical order
//   all_match     out 1            every logical pair valid and equal to TRAIN_BASE+k
//   any_invalid   out 1            at least one physical pair not valid
module link_pair_matcher
  import link_pair_pkg::*;
#(
  parameter int              PAIRS      = 4,
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] TRAIN_BASE = 8'hA0
) (
  input  logic [PAIRS*WIDTH-1:0] rx_symbol,
  input  logic [PAIRS-1:0]       rx_valid,
  input  logic                   crossed,
  output logic [PAIRS*WIDTH-1:0] mapped_symbol,
  output logic                   all_match,
  output logic                   any_invalid
);

  logic [PAIRS-1:0] pair_ok;

  generate
    for (genvar gi = 0; gi < PAIRS; gi++) begin : g_pair
      localparam int               PHYS_S    = map_pair(gi, 1'b0);
      localparam int               PHYS_X    = map_pair(gi, 1'b1);
      // Training symbol wraps modulo 2^WIDTH.
      localparam logic [WIDTH-1:0] TRAIN_SYM = TRAIN_BASE + WIDTH'(gi);

      logic [WIDTH-1:0] sym;
      logic             vld;

      assign sym = crossed ? rx_symbol[PHYS_X*WIDTH +: WIDTH]
                           : rx_symbol[PHYS_S*WIDTH +: WIDTH];
      assign vld = crossed ? rx_valid[PHYS_X] : rx_valid[PHYS_S];

      assign mapped_symbol[gi*WIDTH +: WIDTH] = sym;
      assign pair_ok[gi] = vld && (sym == TRAIN_SYM);
    end
  endgenerate

  assign all_match   = &pair_ok;
  // Loss is about the cable as a whole, so mapping does not matter here.
  assign any_invalid = ~&rx_valid;

endmodule

// File: rtl/link_pair_router.sv
// link_pair_router
// Detects straight vs. crossed pair wiring by locking onto a training
// pattern, then forwards symbols in logical pair order; falls back to
// search after a run of invalid cycles.
// Ports:
//   Clock100MhzP in  1            clock, rising edge
//   Reset        in  1            asynchronous, active-high
//   Enable       in  1            0 forces IDLE on the next edge
//   RxSymbol     in  PAIRS*WIDTH  physical pair symbols
//   RxValid      in  PAIRS        physical pair valids
//   OutSymbol    out PAIRS*WIDTH  registered symbols in logical order
//   OutValid     out 1            OutSymbol valid (LINK only)
//   LinkUp       out 1            state is LINK
//   Crossed      out 1            current/locked mapping is crossed
//   Searching    out 1            state is SEEK
module link_pair_router
  import link_pair_pkg::*;
#(
  parameter int               PAIRS        = 4,
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TRAIN_BASE   = 8'hA0,
  parameter int               LOCK_COUNT   = 16,
  parameter int               SEEK_TIMEOUT = 1024,
  parameter int               LOSS_COUNT   = 8
) (
  input  logic                   Clock100MhzP,
  input  logic                   Reset,
  input  logic                   Enable,
  input  logic [PAIRS*WIDTH-1:0] RxSymbol,
  input  logic [PAIRS-1:0]       RxValid,
  output logic [PAIRS*WIDTH-1:0] OutSymbol,
  output logic                   OutValid,
  output logic                   LinkUp,
  output logic                   Crossed,
  output logic                   Searching
);

  localparam int MATCH_W = cnt_width(LOCK_COUNT);
  localparam int SEEK_W  = cnt_width(SEEK_TIMEOUT - 1);
  localparam int LOSS_W  = cnt_width(LOSS_COUNT);

  localparam logic [MATCH_W-1:0] MATCH_MAX  = MATCH_W'(LOCK_COUNT);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [SEEK_W-1:0]  SEEK_LAST  = SEEK_W'(SEEK_TIMEOUT - 1);
  localparam logic [LOSS_W-1:0]  LOSS_MAX   = LOSS_W'(LOSS_COUNT);
  localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_COUNT - 1);

  state_t                   state_reg, state_next;
  logic [MATCH_W-1:0]       match_cnt_reg, match_cnt_next;
  logic [SEEK_W-1:0]        seek_cnt_reg, seek_cnt_next;
  logic [LOSS_W-1:0]        loss_cnt_reg, loss_cnt_next;
  logic                     crossed_reg, crossed_next;
  logic [PAIRS*WIDTH-1:0]   out_symbol_reg, out_symbol_next;
  logic                     out_valid_reg, out_valid_next;

  logic [PAIRS*WIDTH-1:0]   mapped_symbol;
  logic                     all_match;
  logic                     any_invalid;

  link_pair_matcher #(
    .PAIRS      (PAIRS),
    .WIDTH      (WIDTH),
    .TRAIN_BASE (TRAIN_BASE)
  ) u_matcher (
    .rx_symbol     (RxSymbol),
    .rx_valid      (RxValid),
    .crossed       (crossed_reg),
    .mapped_symbol (mapped_symbol),
    .all_match     (all_match),
    .any_invalid   (any_invalid)
  );

  always_ff @(posedge Clock100MhzP or posedge Reset) begin
    if (Reset) begin
      state_reg      <= IDLE;
      match_cnt_reg  <= '0;
      seek_cnt_reg   <= '0;
      loss_cnt_reg   <= '0;
      crossed_reg    <= 1'b0;
      out_symbol_reg <= '0;
      out_valid_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      match_cnt_reg  <= match_cnt_next;
      seek_cnt_reg   <= seek_cnt_next;
      loss_cnt_reg   <= loss_cnt_next;
      crossed_reg    <= crossed_next;
      out_symbol_reg <= out_symbol_next;
      out_valid_reg  <= out_valid_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    match_cnt_next  = match_cnt_reg;
    seek_cnt_next   = seek_cnt_reg;
    loss_cnt_next   = loss_cnt_reg;
    crossed_next    = crossed_reg;
    out_symbol_next = out_symbol_reg;
    out_valid_next  = 1'b0;

    if (!Enable) begin
      state_next     = IDLE;
      match_cnt_next = '0;
      seek_cnt_next  = '0;
      loss_cnt_next  = '0;
      crossed_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next     = SEEK;
          match_cnt_next = '0;
          seek_cnt_next  = '0;
          loss_cnt_next  = '0;
        end

        SEEK: begin
          // Lock is tested first so a lock on the last cycle of a
          // candidate's window keeps that candidate.
          if (all_match && (match_cnt_reg >= MATCH_LAST)) begin
            state_next     = LINK;
            match_cnt_next = '0;
            seek_cnt_next  = '0;
            loss_cnt_next  = '0;
          end else if (seek_cnt_reg == SEEK_LAST) begin
            crossed_next   = ~crossed_reg;
            match_cnt_next = '0;
            seek_cnt_next  = '0;
          end else begin
            seek_cnt_next = seek_cnt_reg + 1'b1;
            if (!all_match) begin
              match_cnt_next = '0;
            end else if (match_cnt_reg != MATCH_MAX) begin
              match_cnt_next = match_cnt_reg + 1'b1;
            end
          end
        end

        LINK: begin
          out_symbol_next = mapped_symbol;
          out_valid_next  = ~any_invalid;
          if (!any_invalid) begin
            loss_cnt_next = '0;
          end else if (loss_cnt_reg >= LOSS_LAST) begin
            // Resume search with the mapping that was just in use.
            state_next     = SEEK;
            loss_cnt_next  = '0;
            match_cnt_next = '0;
            seek_cnt_next  = '0;
          end else if (loss_cnt_reg != LOSS_MAX) begin
            loss_cnt_next = loss_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign OutSymbol = out_symbol_reg;
  assign OutValid  = out_valid_reg;
  assign LinkUp    = (state_reg == LINK);
  assign Searching = (state_reg == SEEK);
  assign Crossed   = crossed_reg;

endmodule

// File: tb/tb_link_pair_router.sv
module tb_link_pair_router;

  localparam int PAIRS = 4;
  localparam int WIDTH = 8;

  logic                   Clock100MhzP;
  logic                   Reset;
  logic                   Enable;
  logic [PAIRS*WIDTH-1:0] RxSymbol;
  logic [PAIRS-1:0]       RxValid;
  logic [PAIRS*WIDTH-1:0] OutSymbol;
  logic                   OutValid;
  logic                   LinkUp;
  logic                   Crossed;
  logic                   Searching;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Physical pair p lives at bits [p*8 +: 8].
  localparam logic [31:0] TRAIN_S = 32'hA3A2A1A0; // straight: A0,A1,A2,A3
  localparam logic [31:0] TRAIN_X = 32'hA2A3A0A1; // crossed:  A1,A0,A3,A2
  localparam logic [31:0] TRAIN_B = 32'hA3FFA1A0; // pair 2 corrupted

  link_pair_router dut (
    .Clock100MhzP (Clock100MhzP),
    .Reset        (Reset),
    .Enable       (Enable),
    .RxSymbol     (RxSymbol),
    .RxValid      (RxValid),
    .OutSymbol    (OutSymbol),
    .OutValid     (OutValid),
    .LinkUp       (LinkUp),
    .Crossed      (Crossed),
    .Searching    (Searching)
  );

  initial Clock100MhzP = 1'b0;
  always #5 Clock100MhzP = ~Clock100MhzP;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("pass %s got=%0h", tag, got);
    end
  endtask

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock100MhzP);
      #1;
    end
  endtask

  initial begin
    Reset    = 1'b1;
    Enable   = 1'b0;
    RxSymbol = '0;
    RxValid  = '0;
    #2;
    check("rst_linkup",    32'(LinkUp),    32'd0);
    check("rst_outvalid",  32'(OutValid),  32'd0);
    check("rst_outsymbol", OutSymbol,      32'd0);
    check("rst_crossed",   32'(Crossed),   32'd0);
    check("rst_searching", 32'(Searching), 32'd0);

    @(posedge Clock100MhzP);
    #1;
    Reset = 1'b0;
    tick(1);
    check("idle_hold_searching", 32'(Searching), 32'd0);

    // Straight lock.
    RxSymbol = TRAIN_S;
    RxValid  = 4'hF;
    Enable   = 1'b1;
    tick(1);
    check("s_seek_entry", 32'(Searching), 32'd1);
    tick(15);
    check("s_match15_linkup", 32'(LinkUp), 32'd0);
    tick(1);
    check("s_lock_linkup",    32'(LinkUp),    32'd1);
    check("s_lock_crossed",   32'(Crossed),   32'd0);
    check("s_lock_searching", 32'(Searching), 32'd0);

    RxSymbol = 32'h44332211;
    tick(1);
    check("s_data_symbol", OutSymbol,     32'h44332211);
    check("s_data_valid",  32'(OutValid), 32'd1);

    // Loss: 7 invalid cycles do not drop the link.
    RxValid = 4'b1011;
    tick(7);
    check("loss7_linkup",   32'(LinkUp),   32'd1);
    check("loss7_outvalid", 32'(OutValid), 32'd0);
    RxValid = 4'hF;
    tick(1);
    check("loss7_recover_linkup",   32'(LinkUp),   32'd1);
    check("loss7_recover_outvalid", 32'(OutValid), 32'd1);
    RxValid = 4'b1011;
    tick(7);
    check("loss8_pre_linkup", 32'(LinkUp), 32'd1);
    tick(1);
    check("loss8_linkup",    32'(LinkUp),    32'd0);
    check("loss8_searching", 32'(Searching), 32'd1);
    check("loss8_crossed",   32'(Crossed),   32'd0);
    check("loss8_outvalid",  32'(OutValid),  32'd0);

    // Broken training: mismatch in place of the 15th match.
    RxValid  = 4'hF;
    RxSymbol = TRAIN_S;
    tick(14);
    RxSymbol = TRAIN_B;
    tick(1);
    RxSymbol = TRAIN_S;
    tick(15);
    check("broken_pre_linkup", 32'(LinkUp), 32'd0);
    tick(1);
    check("broken_lock_linkup", 32'(LinkUp), 32'd1);

    // Enable drop from LINK.
    Enable = 1'b0;
    tick(1);
    check("dis_link_linkup",    32'(LinkUp),    32'd0);
    check("dis_link_searching", 32'(Searching), 32'd0);
    check("dis_link_outvalid",  32'(OutValid),  32'd0);

    // Crossed lock after straight candidate times out.
    RxSymbol = TRAIN_X;
    Enable   = 1'b1;
    tick(1);
    check("x_seek_entry", 32'(Searching), 32'd1);
    tick(1023);
    check("x_pre_toggle_crossed",   32'(Crossed),   32'd0);
    check("x_pre_toggle_searching", 32'(Searching), 32'd1);
    tick(1);
    check("x_toggle_crossed", 32'(Crossed), 32'd1);
    check("x_toggle_linkup",  32'(LinkUp),  32'd0);
    tick(15);
    check("x_match15_linkup", 32'(LinkUp), 32'd0);
    tick(1);
    check("x_lock_linkup",  32'(LinkUp),  32'd1);
    check("x_lock_crossed", 32'(Crossed), 32'd1);

    RxSymbol = 32'h44332211;
    tick(1);
    check("x_data_symbol", OutSymbol,     32'h33441122);
    check("x_data_valid",  32'(OutValid), 32'd1);

    // Loss in crossed mapping keeps Crossed.
    RxValid = 4'b1011;
    tick(8);
    check("x_loss_linkup",    32'(LinkUp),    32'd0);
    check("x_loss_searching", 32'(Searching), 32'd1);
    check("x_loss_crossed",   32'(Crossed),   32'd1);

    // Enable drop mid-SEEK clears Crossed.
    RxValid = 4'hF;
    tick(3);
    Enable = 1'b0;
    tick(1);
    check("dis_seek_searching", 32'(Searching), 32'd0);
    check("dis_seek_crossed",   32'(Crossed),   32'd0);

    // Lock lands on the last cycle of the straight window.
    RxSymbol = 32'h0;
    Enable   = 1'b1;
    tick(1);
    check("col_seek_entry", 32'(Searching), 32'd1);
    tick(1008);
    RxSymbol = TRAIN_S;
    tick(15);
    check("col_pre_linkup",  32'(LinkUp),  32'd0);
    check("col_pre_crossed", 32'(Crossed), 32'd0);
    tick(1);
    check("col_lock_linkup",  32'(LinkUp),  32'd1);
    check("col_lock_crossed", 32'(Crossed), 32'd0);

    // Asynchronous reset mid-LINK.
    RxSymbol = 32'h55667788;
    tick(1);
    check("arst_pre_outvalid", 32'(OutValid), 32'd1);
    check("arst_pre_symbol",   OutSymbol,     32'h55667788);
    #3;
    Reset = 1'b1;
    #1;
    check("arst_linkup",    32'(LinkUp),    32'd0);
    check("arst_outvalid",  32'(OutValid),  32'd0);
    check("arst_outsymbol", OutSymbol,      32'd0);
    check("arst_searching", 32'(Searching), 32'd0);
    Enable = 1'b0;
    #1;
    Reset = 1'b0;
    tick(2);
    check("arst_idle_searching", 32'(Searching), 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
